// File: rtl/send_port_arbiter.sv
// Arbitrates NUM_REQ local flit sources onto one credited network send port.
// Packets are atomic: once a head is accepted, only its owner is served until its tail.
module send_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_VCS         = 2,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2,
  parameter int CREDIT_MAX      = 8,
  localparam int VC_BITS        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW             = $clog2(CREDIT_MAX + 1),
  localparam int FW             = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*FW-1:0]  req_flit,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [FW-1:0]          net_flit,
  output logic                   net_put,
  input  logic [NUM_VCS-1:0]     credit_ret,
  output logic [NUM_VCS*CW-1:0]  credits,
  output logic                   busy,
  output logic                   credit_err,
  output logic [31:0]            flits_sent
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [RW-1:0]       owner_q, owner_d;
  logic [CW-1:0]       credits_q [NUM_VCS];
  logic [CW-1:0]       credits_d [NUM_VCS];
  logic                credit_err_q, credit_err_d;
  logic                net_put_q, net_put_d;
  logic [FW-1:0]       net_flit_q, net_flit_d;
  logic [31:0]         flits_sent_q, flits_sent_d;

  logic [FW-1:0]       flit_arr [NUM_REQ];
  logic [NUM_VCS-1:0]  credit_avail;
  logic [RW-1:0]       cand;
  logic [RW-1:0]       grant_idx;
  logic                grant_found;
  logic [FW-1:0]       grant_flit;
  logic                accept;
  logic                acc_tail;
  logic [VC_BITS-1:0]  acc_vc;

  function automatic logic vc_has_credit(input logic [VC_BITS-1:0] vc,
                                         input logic [NUM_VCS-1:0] avail);
    logic ok;
    ok = 1'b0;
    // A vc code with no matching channel never finds credit, so it is never served.
    for (int v = 0; v < NUM_VCS; v++) begin
      if (vc == VC_BITS'(v)) ok = avail[v];
    end
    return ok;
  endfunction

  function automatic logic [RW-1:0] next_ptr(input logic [RW-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + RW'(1);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign flit_arr[i] = req_flit[i*FW +: FW];
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      credit_avail[v] = (credits_q[v] != '0);
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (accept) begin
      if (acc_tail) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr(grant_idx);
      end else begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end
    end
  end

  // Output logic: grant selection and handshake
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state_q == LOCKED) begin
      grant_found = req_valid[owner_q];
      grant_idx   = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = RW'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
    grant_flit = flit_arr[grant_idx];
    acc_tail   = grant_flit[FW-2];
    acc_vc     = grant_flit[FLIT_DATA_WIDTH +: VC_BITS];
    // A winner without credit stalls the port rather than passing the grant on.
    accept     = grant_found && vc_has_credit(acc_vc, credit_avail) && !RESET;
    req_ready  = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    busy       = (state_q == LOCKED);
  end

  always_comb begin
    net_put_d    = accept;
    net_flit_d   = accept ? (grant_flit | {1'b1, {(FW-1){1'b0}}}) : '0;
    flits_sent_d = flits_sent_q + 32'(net_put_q);
    credit_err_d = credit_err_q;
    for (int v = 0; v < NUM_VCS; v++) begin
      credits_d[v] = credits_q[v];
      if (accept && acc_vc == VC_BITS'(v)) begin
        if (!credit_ret[v]) credits_d[v] = credits_q[v] - CW'(1);
      end else if (credit_ret[v]) begin
        if (credits_q[v] == CW'(CREDIT_MAX)) credit_err_d = 1'b1;
        else credits_d[v] = credits_q[v] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      net_put_q    <= 1'b0;
      net_flit_q   <= '0;
      flits_sent_q <= '0;
      credit_err_q <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) credits_q[v] <= CW'(CREDIT_MAX);
    end else begin
      net_put_q    <= net_put_d;
      net_flit_q   <= net_flit_d;
      flits_sent_q <= flits_sent_d;
      credit_err_q <= credit_err_d;
      for (int v = 0; v < NUM_VCS; v++) credits_q[v] <= credits_d[v];
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      credits[v*CW +: CW] = credits_q[v];
    end
  end

  assign net_put    = net_put_q;
  assign net_flit   = net_flit_q;
  assign credit_err = credit_err_q;
  assign flits_sent = flits_sent_q;

endmodule

// File: tb/tb_send_port_arbiter.sv
// Directed scenarios plus randomized traffic for send_port_arbiter,
// checked against a rule-level reference model of the arbiter and credit counters.
module tb_send_port_arbiter;
  localparam int NUM_REQ = 4, NUM_VCS = 2, FLIT_DATA_WIDTH = 32, DEST_BITS = 2, CREDIT_MAX = 8;
  localparam int VC_BITS = 1, CW = 4, FW = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*FW-1:0] req_flit;
  logic [NUM_REQ-1:0]    req_ready;
  logic [FW-1:0]         net_flit;
  logic                  net_put;
  logic [NUM_VCS-1:0]    credit_ret;
  logic [NUM_VCS*CW-1:0] credits;
  logic                  busy;
  logic                  credit_err;
  logic [31:0]           flits_sent;

  send_port_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_VCS(NUM_VCS), .FLIT_DATA_WIDTH(FLIT_DATA_WIDTH),
    .DEST_BITS(DEST_BITS), .CREDIT_MAX(CREDIT_MAX)
  ) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_flit(req_flit),
    .req_ready(req_ready), .net_flit(net_flit), .net_put(net_put),
    .credit_ret(credit_ret), .credits(credits), .busy(busy),
    .credit_err(credit_err), .flits_sent(flits_sent)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int last_grant;

  // Reference model state
  int            m_locked, m_rr, m_owner, m_err;
  int            m_cred [NUM_VCS];
  bit            m_put;
  logic [FW-1:0] m_net;
  logic [31:0]   m_sent;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [FW-1:0] mk_flit(input bit tail, input int dest, input int vc,
                                            input logic [31:0] data);
    return {1'b1, tail, DEST_BITS'(dest), VC_BITS'(vc), data};
  endfunction

  task automatic set_req(input int i, input bit v, input logic [FW-1:0] f);
    req_valid[i]          = v;
    req_flit[i*FW +: FW]  = f;
  endtask

  task automatic model_reset();
    m_locked = 0; m_rr = 0; m_owner = 0; m_err = 0;
    m_put = 0; m_net = '0; m_sent = '0;
    for (int v = 0; v < NUM_VCS; v++) m_cred[v] = CREDIT_MAX;
  endtask

  function automatic int model_grant();
    int cand;
    int vc;
    logic [FW-1:0] f;
    cand = -1;
    if (m_locked != 0) begin
      if (req_valid[m_owner]) cand = m_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_rr + k) % NUM_REQ;
        if (cand < 0 && req_valid[idx]) cand = idx;
      end
    end
    if (cand < 0) return -1;
    f  = req_flit[cand*FW +: FW];
    vc = int'(f[FLIT_DATA_WIDTH +: VC_BITS]);
    if (vc >= NUM_VCS || m_cred[vc] == 0) return -1;
    return cand;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, ":ready"}, req_ready, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":put"}, net_put, 0);
    check({tag, ":flit"}, net_flit, 0);
    check({tag, ":credits"}, credits, {CW'(CREDIT_MAX), CW'(CREDIT_MAX)});
    check({tag, ":err"}, credit_err, 0);
    check({tag, ":sent"}, flits_sent, 0);
  endtask

  // One clock: check combinational handshake, then the registered results of the edge.
  task automatic cycle(input string tag);
    int g;
    int fvc;
    logic [FW-1:0]      f;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [NUM_VCS-1:0] cr;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check({tag, ":ready"}, req_ready, exp_rdy);
    check({tag, ":busy"}, busy, (m_locked != 0) ? 1 : 0);
    last_grant = g;
    cr = credit_ret;
    f  = (g >= 0) ? req_flit[g*FW +: FW] : '0;
    @(posedge CLK);
    #1;
    m_sent = m_sent + 32'(m_put);
    fvc = -1;
    if (g >= 0) begin
      m_put = 1;
      m_net = f;
      m_net[FW-1] = 1'b1;
      fvc = int'(f[FLIT_DATA_WIDTH +: VC_BITS]);
      if (f[FW-2]) begin
        m_locked = 0;
        m_rr = (g + 1) % NUM_REQ;
      end else begin
        m_locked = 1;
        m_owner = g;
      end
    end else begin
      m_put = 0;
      m_net = '0;
    end
    for (int v = 0; v < NUM_VCS; v++) begin
      if (fvc == v && cr[v]) begin
      end else if (fvc == v) m_cred[v]--;
      else if (cr[v]) begin
        if (m_cred[v] == CREDIT_MAX) m_err = 1;
        else m_cred[v]++;
      end
    end
    check({tag, ":put"}, net_put, m_put);
    check({tag, ":flit"}, net_flit, m_net);
    for (int v = 0; v < NUM_VCS; v++) check({tag, ":cred"}, credits[v*CW +: CW], m_cred[v]);
    check({tag, ":err"}, credit_err, m_err);
    check({tag, ":sent"}, flits_sent, m_sent);
  endtask

  task automatic do_reset(input string tag);
    RESET = 1'b1;
    req_valid = '0;
    req_flit = '0;
    credit_ret = '0;
    model_reset();
    #1;
    check_reset_state(tag);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    req_valid = '0;
    req_flit = '0;
    credit_ret = '0;
    model_reset();
    #12;
    do_reset("por");

    // Single flit from requester 0
    set_req(0, 1'b1, mk_flit(1'b1, 1, 0, 32'hA));
    cycle("single");
    check("single:grant", last_grant, 0);
    check("single:netflit", net_flit, {1'b1, 1'b1, 2'd1, 1'b0, 32'h0000000A});
    check("single:cred0", credits[3:0], 7);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, mk_flit(1'b1, i, i % 2, 32'(i)));
    cycle("single_next");
    check("single:rr", last_grant, 1);

    // Round-robin with everyone valid
    do_reset("rst_rr");
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, mk_flit(1'b1, i, i % 2, 32'h100 + 32'(i)));
    for (int k = 0; k < 5; k++) begin
      cycle("rr");
      check("rr:order", last_grant, k % NUM_REQ);
      check("rr:put", net_put, 1);
    end

    // Packet lock: requester 2 sends 3 flits while requester 1 waits
    do_reset("rst_pkt");
    set_req(1, 1'b1, mk_flit(1'b1, 0, 0, 32'h11));
    cycle("pkt_pre");
    check("pkt_pre:grant", last_grant, 1);
    set_req(2, 1'b1, mk_flit(1'b0, 3, 1, 32'h20));
    cycle("pkt_head");
    check("pkt_head:grant", last_grant, 2);
    check("pkt_head:busy", busy, 1);
    set_req(2, 1'b1, mk_flit(1'b0, 3, 1, 32'h21));
    cycle("pkt_body");
    check("pkt_body:grant", last_grant, 2);
    check("pkt_body:busy", busy, 1);
    set_req(2, 1'b1, mk_flit(1'b1, 3, 1, 32'h22));
    cycle("pkt_tail");
    check("pkt_tail:grant", last_grant, 2);
    check("pkt_tail:busy", busy, 0);
    set_req(2, 1'b0, '0);
    cycle("pkt_after");
    check("pkt_after:grant", last_grant, 1);

    // Credit exhaustion on VC 0
    do_reset("rst_cred");
    set_req(0, 1'b1, mk_flit(1'b1, 2, 0, 32'hC0));
    for (int k = 0; k < 8; k++) begin
      cycle("exh");
      check("exh:grant", last_grant, 0);
    end
    check("exh:cred0", credits[3:0], 0);
    for (int k = 0; k < 2; k++) begin
      cycle("stall");
      check("stall:grant", last_grant, -1);
    end
    credit_ret = 2'b01;
    cycle("ret");
    check("ret:grant", last_grant, -1);
    check("ret:cred0", credits[3:0], 1);
    credit_ret = 2'b00;
    cycle("ninth");
    check("ninth:grant", last_grant, 0);
    check("ninth:cred0", credits[3:0], 0);

    // Credit overflow and simultaneous send+return
    do_reset("rst_ovf");
    credit_ret = 2'b10;
    cycle("ovf");
    check("ovf:cred1", credits[7:4], 8);
    check("ovf:err", credit_err, 1);
    credit_ret = 2'b00;
    set_req(0, 1'b1, mk_flit(1'b1, 0, 0, 32'h55));
    cycle("snd");
    check("snd:cred0", credits[3:0], 7);
    credit_ret = 2'b01;
    cycle("sndret");
    check("sndret:grant", last_grant, 0);
    check("sndret:cred0", credits[3:0], 7);
    check("sndret:err", credit_err, 1);
    credit_ret = 2'b00;

    // Asynchronous reset in the middle of a packet
    do_reset("rst_mid");
    set_req(1, 1'b1, mk_flit(1'b1, 1, 1, 32'h71));
    cycle("mid_a");
    cycle("mid_b");
    set_req(1, 1'b0, '0);
    set_req(2, 1'b1, mk_flit(1'b0, 2, 0, 32'h72));
    cycle("mid_head");
    check("mid_head:busy", busy, 1);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, mk_flit(1'b1, i, i % 2, 32'h80 + 32'(i)));
    #2;
    RESET = 1'b1;
    #1;
    check_reset_state("async");
    #2;
    RESET = 1'b0;
    model_reset();
    cycle("mid_after");
    check("mid_after:grant", last_grant, 0);

    // Randomized traffic
    do_reset("rst_rand");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        logic [FW-1:0] f;
        f = mk_flit($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 1)), $urandom);
        f[FW-1] = 1'($urandom_range(0, 1));
        set_req(i, $urandom_range(0, 3) != 0, f);
      end
      for (int v = 0; v < NUM_VCS; v++) credit_ret[v] = ($urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/send_port_arbiter.md
SEND_PORT_ARBITER -- requirements
Module: send_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of local requesters sharing one network send port.
REQ-002 SHALL have parameter NUM_VCS, default 2, meaning the virtual channels per send port; VC_BITS = clog2(NUM_VCS), or 1 when NUM_VCS = 1.
REQ-003 SHALL have parameter FLIT_DATA_WIDTH, default 32, meaning the flit payload bits.
REQ-004 SHALL have parameter DEST_BITS, default 2, meaning the destination field bits.
REQ-005 SHALL have parameter CREDIT_MAX, default 8, meaning the router input buffer depth per VC; CW = clog2(CREDIT_MAX+1).
REQ-006 SHALL define FW = 2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH, with the flit laid out MSB first as {valid, tail, dest, vc, data}.
REQ-007 SHALL have port CLK, input, 1, the single clock, rising edge.
REQ-008 SHALL have port RESET, input, 1, an asynchronous active-high reset.
REQ-009 SHALL have port req_valid, input, NUM_REQ, the per-requester flit-offered strobe.
REQ-010 SHALL have port req_flit, input, NUM_REQ*FW, the per-requester flit, with requester i at bits [i*FW +: FW].
REQ-011 SHALL have port req_ready, output, NUM_REQ, the per-requester flit-accepted strobe.
REQ-012 SHALL have port net_flit, output, FW, the flit driven to the network putFlit_flit_in.
REQ-013 SHALL have port net_put, output, 1, driven to the network EN_putFlit.
REQ-014 SHALL have port credit_ret, input, NUM_VCS, one credit returned per set bit from the network getNonFullVCs.
REQ-015 SHALL have port credits, output, NUM_VCS*CW, the current credit count per VC.
REQ-016 SHALL have port busy, output, 1, which is high while a packet is locked.
REQ-017 SHALL have port credit_err, output, 1, a sticky flag for credit overflow.
REQ-018 SHALL have port flits_sent, output, 32, the count of flits put to the network.

Function
REQ-019 SHALL accept a flit from requester i only in a cycle where req_valid[i] && req_ready[i] (the handshake).
REQ-020 SHALL assert at most one req_ready bit per cycle.
REQ-021 SHALL drive req_ready[i] independently of req_valid[i] only through arbitration; ready requires the grant and credits[vc of req_flit[i]] > 0.
REQ-022 SHALL implement two FSM states, IDLE and LOCKED.
REQ-023 SHALL, in IDLE, grant the first valid requester found searching from rr_ptr upward, modulo NUM_REQ, in the same cycle.
REQ-024 SHALL, in IDLE, leave a requester that wins arbitration but lacks a credit on its VC not ready, with no state change and no grant to any other requester.
REQ-025 SHALL, on an IDLE accept with tail=0, go to LOCKED with owner = i.
REQ-026 SHALL, on an IDLE accept with tail=1, stay in IDLE and set rr_ptr = (i+1) mod NUM_REQ.
REQ-027 SHALL, in LOCKED, consider only the owner; all other req_ready bits are 0.
REQ-028 SHALL, in LOCKED, on accepting a tail flit, go to IDLE and set rr_ptr = (owner+1) mod NUM_REQ.
REQ-029 SHALL drive busy = 1 exactly when in LOCKED.
REQ-030 SHALL register net_flit and net_put: a flit accepted at cycle N appears at cycle N+1 with net_put = 1 and the valid bit forced to 1; otherwise net_put = 0 and net_flit = 0.
REQ-031 SHALL decrement credits[v] by 1 on an accept on VC v.
REQ-032 SHALL increment credits[v] by 1 on credit_ret[v].
REQ-033 SHALL leave credits[v] unchanged when an accept and a return on VC v occur in the same cycle.
REQ-034 SHALL hold credits[v] at CREDIT_MAX and set credit_err when a return arrives at CREDIT_MAX with no simultaneous send; credit_err clears only on reset.
REQ-035 SHALL ignore req_flit bits whose vc field is >= NUM_VCS by never making that requester ready.
REQ-036 SHALL increment flits_sent on each net_put = 1 cycle, wrapping from 2^32-1 to 0.

Reset
REQ-037 SHALL, on RESET asserted, immediately force: state IDLE, rr_ptr 0, owner 0, all credits CREDIT_MAX, net_put 0, net_flit 0, req_ready 0, busy 0, credit_err 0, flits_sent 0.
REQ-038 SHALL, on reset asserted mid-packet, abandon the packet with no flit emitted; the requester must restart its packet from the head.

Verification
REQ-039 SHALL pass this scenario: requester 0 sends a single flit {tail=1, dest=1, vc=0, data=0xA} at cycle 5 -> net_put=1 at cycle 6 with that flit, credits[0]=7, rr_ptr=1.
REQ-040 SHALL pass this scenario: all four requesters valid with single-tail flits every cycle -> grants occur in order 0,1,2,3,0; one flit per cycle; no gaps.
REQ-041 SHALL pass this scenario: requester 2 sends a 3-flit packet (head, body, tail) while requester 1 is valid throughout -> three consecutive grants to 2, busy high for 2 cycles, then requester 1 is granted.
REQ-042 SHALL pass this scenario: no credit_ret, 9 flits on VC 0 -> 8 accepted, credits[0]=0, the 9th stalls until a credit_ret[0] pulse, then is accepted the next cycle.
REQ-043 SHALL pass this scenario: credit_ret[1] pulsed with credits[1]=8 -> credits stays 8 and credit_err=1; a simultaneous send plus return on VC 0 leaves credits[0] unchanged.
REQ-044 SHALL pass this scenario: RESET asserted in LOCKED after the head flit -> all outputs immediately at reset values; after release, requester 0 is granted first.
